// File: rtl/pump_sequencer.sv
// Pump sequencer: debounced criticality drives a fill/drain FSM for pumps A and B.
// Optional soft-start duty ramp is enabled by defining PUMP_SEQ_SOFT_RAMP_EN.
module pump_sequencer #(
   parameter int STATUS_W             = 4,
   parameter int PWM_W                = 8,
   parameter int PWM_MAX              = 230,
   parameter int PWM_MIN              = 77,
   parameter int CRIT_DEBOUNCE_CYCLES = 50_000,
   parameter int MIN_DWELL_CYCLES     = 250_000_000,
   parameter int FILL_TIMEOUT_CYCLES  = 1_500_000_000,
   parameter int RAMP_STEP_CYCLES     = 50_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [STATUS_W-1:0] status_data,
   input  logic                level_a_full,
   input  logic                level_b_empty,
   input  logic                fault_clear,
   output logic [PWM_W-1:0]    pwm_duty_a,
   output logic [PWM_W-1:0]    pwm_duty_b,
   output logic                is_critical,
   output logic                fault,
   output logic [2:0]          state_o
);

   if (PWM_MIN < 0 || PWM_MIN > PWM_MAX || (PWM_MAX >> PWM_W) != 0 ||
       CRIT_DEBOUNCE_CYCLES < 1 || MIN_DWELL_CYCLES < 1 ||
       FILL_TIMEOUT_CYCLES < 1 || RAMP_STEP_CYCLES < 1) begin : g_param_check
      $error("pump_sequencer: illegal parameter combination");
   end

   localparam int CRIT_W  = $clog2(CRIT_DEBOUNCE_CYCLES + 1);
   localparam int DWELL_W = $clog2(MIN_DWELL_CYCLES + 1);
   localparam int FILL_W  = $clog2(FILL_TIMEOUT_CYCLES + 1);

   localparam logic [CRIT_W-1:0]  CRIT_LAST  = CRIT_W'(CRIT_DEBOUNCE_CYCLES - 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(MIN_DWELL_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(MIN_DWELL_CYCLES - 1);
   localparam logic [FILL_W-1:0]  FILL_MAX   = FILL_W'(FILL_TIMEOUT_CYCLES);
   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(FILL_TIMEOUT_CYCLES - 1);
   localparam logic [PWM_W-1:0]   DUTY_MAX   = PWM_W'(PWM_MAX);
   localparam logic [PWM_W-1:0]   DUTY_MIN   = PWM_W'(PWM_MIN);

   typedef enum logic [2:0] {
      ST_STOP      = 3'd0,
      ST_FILLING   = 3'd1,
      ST_DRAIN_MIN = 3'd2,
      ST_DRAIN_MAX = 3'd3,
      ST_STOPPING  = 3'd4,
      ST_FAULT     = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic               crit_q, crit_d;
   logic [CRIT_W-1:0]  crit_cnt_q, crit_cnt_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
   logic [PWM_W-1:0]   target [2];
   logic [PWM_W-1:0]   pwm_q [2];
   logic [PWM_W-1:0]   pwm_d [2];
   logic               crit_raw;
   logic               dwell_done;
   logic               fill_done;

   assign crit_raw = |status_data;

   // A pending change only commits after CRIT_DEBOUNCE_CYCLES stable samples.
   always_comb begin
      crit_d     = crit_q;
      crit_cnt_d = '0;
      if (crit_raw != crit_q) begin
         if (crit_cnt_q >= CRIT_LAST) begin
            crit_d = crit_raw;
         end else begin
            crit_cnt_d = crit_cnt_q + 1'b1;
         end
      end
   end

   // Timers count only in their own state and saturate; the state lasts exactly the limit.
   always_comb begin
      dwell_cnt_d = '0;
      fill_cnt_d  = '0;
      if (state_q == ST_DRAIN_MIN) begin
         dwell_cnt_d = (dwell_cnt_q == DWELL_MAX) ? dwell_cnt_q : dwell_cnt_q + 1'b1;
      end
      if (state_q == ST_FILLING) begin
         fill_cnt_d = (fill_cnt_q == FILL_MAX) ? fill_cnt_q : fill_cnt_q + 1'b1;
      end
   end

   assign dwell_done = (dwell_cnt_q >= DWELL_LAST);
   assign fill_done  = (fill_cnt_q >= FILL_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_STOP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STOP: begin
            if (crit_q) state_d = ST_FILLING;
         end
         ST_FILLING: begin
            if (!crit_q)           state_d = ST_STOPPING;
            else if (!level_a_full) state_d = ST_DRAIN_MIN;
            else if (fill_done)     state_d = ST_FAULT;
         end
         ST_DRAIN_MIN: begin
            if (!crit_q)            state_d = ST_STOPPING;
            else if (level_b_empty) state_d = ST_FILLING;
            else if (dwell_done)    state_d = ST_DRAIN_MAX;
         end
         ST_DRAIN_MAX: begin
            if (!crit_q)            state_d = ST_STOPPING;
            else if (level_b_empty) state_d = ST_FILLING;
         end
         ST_STOPPING: begin
            if (level_b_empty) state_d = ST_STOP;
         end
         ST_FAULT: begin
            if (fault_clear) state_d = ST_STOP;
         end
         default: state_d = ST_STOP;
      endcase
   end

   always_comb begin
      target[0] = '0;
      target[1] = '0;
      case (state_q)
         ST_FILLING: begin
            target[0] = DUTY_MAX;
            target[1] = level_b_empty ? '0 : DUTY_MAX;
         end
         ST_DRAIN_MIN: target[1] = DUTY_MIN;
         ST_DRAIN_MAX: target[1] = DUTY_MAX;
         ST_STOPPING:  target[1] = level_b_empty ? '0 : DUTY_MAX;
         default: begin
            target[0] = '0;
            target[1] = '0;
         end
      endcase
   end

`ifdef PUMP_SEQ_SOFT_RAMP_EN
   localparam int RAMP_W = $clog2(RAMP_STEP_CYCLES + 1);
   localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP_CYCLES - 1);

   logic [RAMP_W-1:0] ramp_cnt_q [2];
   logic [RAMP_W-1:0] ramp_cnt_d [2];

   // Rises step once immediately, then every RAMP_STEP_CYCLES; any drop aborts the ramp.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         pwm_d[i]      = pwm_q[i];
         ramp_cnt_d[i] = '0;
         if (target[i] < pwm_q[i]) begin
            pwm_d[i] = target[i];
         end else if (target[i] > pwm_q[i]) begin
            if (ramp_cnt_q[i] == '0) begin
               pwm_d[i]      = pwm_q[i] + 1'b1;
               ramp_cnt_d[i] = RAMP_LAST;
            end else begin
               ramp_cnt_d[i] = ramp_cnt_q[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) ramp_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) ramp_cnt_q[i] <= ramp_cnt_d[i];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < 2; i++) pwm_d[i] = target[i];
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         crit_q      <= 1'b0;
         crit_cnt_q  <= '0;
         dwell_cnt_q <= '0;
         fill_cnt_q  <= '0;
         for (int i = 0; i < 2; i++) pwm_q[i] <= '0;
      end else begin
         crit_q      <= crit_d;
         crit_cnt_q  <= crit_cnt_d;
         dwell_cnt_q <= dwell_cnt_d;
         fill_cnt_q  <= fill_cnt_d;
         for (int i = 0; i < 2; i++) pwm_q[i] <= pwm_d[i];
      end
   end

   assign pwm_duty_a  = pwm_q[0];
   assign pwm_duty_b  = pwm_q[1];
   assign is_critical = crit_q;
   assign fault       = (state_q == ST_FAULT);
   assign state_o     = state_q;

endmodule

// File: tb/tb_pump_sequencer.sv
// Scoreboard bench for pump_sequencer: stimulus queues expected outputs,
// a negedge monitor pops one entry per cycle and compares.
module tb_pump_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] status_data;
   logic       level_a_full;
   logic       level_b_empty;
   logic       fault_clear;
   logic [7:0] pwm_duty_a;
   logic [7:0] pwm_duty_b;
   logic       is_critical;
   logic       fault;
   logic [2:0] state_o;

   always #5 clk = ~clk;

   pump_sequencer #(
      .STATUS_W(4), .PWM_W(8), .PWM_MAX(230), .PWM_MIN(77),
      .CRIT_DEBOUNCE_CYCLES(4), .MIN_DWELL_CYCLES(10),
      .FILL_TIMEOUT_CYCLES(50), .RAMP_STEP_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset), .status_data(status_data),
      .level_a_full(level_a_full), .level_b_empty(level_b_empty),
      .fault_clear(fault_clear), .pwm_duty_a(pwm_duty_a),
      .pwm_duty_b(pwm_duty_b), .is_critical(is_critical),
      .fault(fault), .state_o(state_o)
   );

   typedef struct {
      string      name;
      logic [2:0] st;
      logic [7:0] da;
      logic [7:0] db;
      logic       crit;
      logic       flt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fails  = 0;

   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [2:0] st,
                              input logic [7:0] da, input logic [7:0] db,
                              input logic crit, input logic flt);
      exp_t e;
      e.name = name; e.st = st; e.da = da; e.db = db; e.crit = crit; e.flt = flt;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         if ({state_o, pwm_duty_a, pwm_duty_b, is_critical, fault} !==
             {mon_e.st, mon_e.da, mon_e.db, mon_e.crit, mon_e.flt}) begin
            n_fails++;
            $display("[TB] FAIL %s: got st=%0d a=%0d b=%0d crit=%0b fault=%0b, want st=%0d a=%0d b=%0d crit=%0b fault=%0b",
                     mon_e.name, state_o, pwm_duty_a, pwm_duty_b, is_critical, fault,
                     mon_e.st, mon_e.da, mon_e.db, mon_e.crit, mon_e.flt);
         end
      end
   end

   initial begin
      reset = 1'b0; status_data = '0; level_a_full = 1'b1;
      level_b_empty = 1'b0; fault_clear = 1'b0;
      applyStimulus(2);
      checkOutput("reset_state", 0, 0, 0, 0, 0);
      reset = 1'b1;

      status_data = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         checkOutput("glitch_hold", 0, 0, 0, 0, 0);
      end
      status_data = '0;
      applyStimulus(1);
      checkOutput("glitch_release", 0, 0, 0, 0, 0);

      status_data = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         checkOutput("debounce_wait", 0, 0, 0, 0, 0);
      end
      applyStimulus(1);
      checkOutput("crit_asserted", 0, 0, 0, 1, 0);
      applyStimulus(1);
      checkOutput("enter_filling", 1, 0, 0, 1, 0);
      applyStimulus(1);
      checkOutput("fill_duty", 1, 230, 230, 1, 0);
      applyStimulus(48);
      checkOutput("fill_before_timeout", 1, 230, 230, 1, 0);
      applyStimulus(1);
      checkOutput("fill_timeout", 5, 230, 230, 1, 1);
      applyStimulus(1);
      checkOutput("fault_duty_off", 5, 0, 0, 1, 1);
      fault_clear = 1'b1;
      applyStimulus(1);
      fault_clear = 1'b0;
      checkOutput("fault_cleared", 0, 0, 0, 1, 0);
      applyStimulus(1);
      checkOutput("refill", 1, 0, 0, 1, 0);
      applyStimulus(1);
      checkOutput("refill_duty", 1, 230, 230, 1, 0);
      fault_clear = 1'b1;
      applyStimulus(1);
      fault_clear = 1'b0;
      checkOutput("clear_ignored", 1, 230, 230, 1, 0);

      level_a_full = 1'b0;
      applyStimulus(1);
      checkOutput("enter_drain_min", 2, 230, 230, 1, 0);
      applyStimulus(1);
      checkOutput("drain_min_duty", 2, 0, 77, 1, 0);
      applyStimulus(8);
      checkOutput("dwell_last", 2, 0, 77, 1, 0);
      applyStimulus(1);
      checkOutput("enter_drain_max", 3, 0, 77, 1, 0);
      applyStimulus(1);
      checkOutput("drain_max_duty", 3, 0, 230, 1, 0);

      status_data = '0;
      applyStimulus(4);
      checkOutput("crit_released", 3, 0, 230, 0, 0);
      applyStimulus(1);
      checkOutput("enter_stopping", 4, 0, 230, 0, 0);
      applyStimulus(1);
      checkOutput("stopping_duty", 4, 0, 230, 0, 0);
      level_b_empty = 1'b1;
      applyStimulus(1);
      checkOutput("stop_on_empty", 0, 0, 0, 0, 0);

      level_b_empty = 1'b0;
      status_data = 4'b0100;
      applyStimulus(4);
      checkOutput("recrit", 0, 0, 0, 1, 0);
      applyStimulus(1);
      checkOutput("fill_again", 1, 0, 0, 1, 0);
      applyStimulus(1);
      checkOutput("drain_again", 2, 230, 230, 1, 0);
      applyStimulus(6);
      reset = 1'b0;
      checkOutput("async_reset", 0, 0, 0, 0, 0);
      applyStimulus(1);
      checkOutput("reset_held", 0, 0, 0, 0, 0);
      reset = 1'b1;
      applyStimulus(3);
      checkOutput("post_reset_debounce", 0, 0, 0, 0, 0);
      applyStimulus(1);
      checkOutput("post_reset_crit", 0, 0, 0, 1, 0);
      applyStimulus(1);
      checkOutput("post_reset_fill", 1, 0, 0, 1, 0);
      applyStimulus(1);
      checkOutput("fresh_drain_min", 2, 230, 230, 1, 0);
      applyStimulus(9);
      checkOutput("fresh_dwell_last", 2, 0, 77, 1, 0);
      applyStimulus(1);
      checkOutput("fresh_drain_max", 3, 0, 77, 1, 0);
      applyStimulus(1);
      checkOutput("fresh_drain_max_duty", 3, 0, 230, 1, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) applyStimulus(1);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fails++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
